// File: rtl/piso_stream_pkg.sv
// rtl/piso_stream_pkg.sv - shared sizing and count helpers for the flow-controlled PISO
package piso_stream_pkg;

    function automatic int calc_num_shifts(input int in_width, input int out_width);
        return in_width / out_width;
    endfunction

    function automatic int calc_count_width(input int num_shifts);
        return $clog2(num_shifts + 1);
    endfunction

    // A count of zero, or one larger than the word holds, means "emit the whole word".
    function automatic int norm_count(input int cnt, input int num_shifts);
        if (cnt == 0 || cnt > num_shifts) begin
            return num_shifts;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// rtl/piso_hold_buf.sv - one-entry holding register for a word waiting on the shifter
module piso_hold_buf #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [CNT_W-1:0]  wr_cnt,
    input  logic              wr_msb,
    input  logic              rd_en,
    output logic              hold_valid,
    output logic [DATA_W-1:0] hold_data,
    output logic [CNT_W-1:0]  hold_cnt,
    output logic              hold_msb
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              msb_q, msb_d;

    // A write in the same cycle as a read refills the entry, so write wins.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        msb_d   = msb_q;
        if (flush) begin
            valid_d = 1'b0;
        end else begin
            if (rd_en) begin
                valid_d = 1'b0;
            end
            if (wr_en) begin
                valid_d = 1'b1;
                data_d  = wr_data;
                cnt_d   = wr_cnt;
                msb_d   = wr_msb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            msb_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            msb_q   <= msb_d;
        end
    end

    assign hold_valid = valid_q;
    assign hold_data  = data_q;
    assign hold_cnt   = cnt_q;
    assign hold_msb   = msb_q;

endmodule

// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - flow-controlled parallel-in/serial-out shifter with hold/bypass entry
module piso_stream
    import piso_stream_pkg::*;
#(
    parameter int  DATA_IN_WIDTH  = 64,
    parameter int  DATA_OUT_WIDTH = 16,
    localparam int NUM_SHIFTS     = calc_num_shifts(DATA_IN_WIDTH, DATA_OUT_WIDTH),
    localparam int COUNT_WIDTH    = calc_count_width(NUM_SHIFTS)
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      FLUSH,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [DATA_IN_WIDTH-1:0]  DATA_IN,
    input  logic [COUNT_WIDTH-1:0]    IN_COUNT,
    input  logic                      IN_MSB_FIRST,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [DATA_OUT_WIDTH-1:0] DATA_OUT,
    output logic                      OUT_LAST,
    output logic                      BUSY
);

    logic [DATA_IN_WIDTH-1:0] serial_q, serial_d;
    logic [COUNT_WIDTH-1:0]   rem_q, rem_d;
    logic                     msb_q, msb_d;

    logic                     hold_valid;
    logic [DATA_IN_WIDTH-1:0] hold_data;
    logic [COUNT_WIDTH-1:0]   hold_cnt;
    logic                     hold_msb;
    logic                     hold_wr;
    logic                     hold_rd;

    logic                     in_ready;
    logic                     in_accept;
    logic                     fire;
    logic                     free;
    logic [COUNT_WIDTH-1:0]   in_cnt_norm;

    assign in_ready    = !hold_valid && !RESET;
    assign in_accept   = IN_VALID && in_ready && !FLUSH;
    assign fire        = (rem_q != '0) && OUT_READY;
    assign free        = (rem_q == '0) || (fire && rem_q == COUNT_WIDTH'(1));
    assign in_cnt_norm = COUNT_WIDTH'(norm_count(int'(IN_COUNT), NUM_SHIFTS));

    piso_hold_buf #(
        .DATA_W (DATA_IN_WIDTH),
        .CNT_W  (COUNT_WIDTH)
    ) u_hold (
        .clk        (CLK),
        .rst        (RESET),
        .flush      (FLUSH),
        .wr_en      (hold_wr),
        .wr_data    (DATA_IN),
        .wr_cnt     (in_cnt_norm),
        .wr_msb     (IN_MSB_FIRST),
        .rd_en      (hold_rd),
        .hold_valid (hold_valid),
        .hold_data  (hold_data),
        .hold_cnt   (hold_cnt),
        .hold_msb   (hold_msb)
    );

    // Shift on fire, then let a waiting hold entry or a bypassing input refill
    // the shifter the same cycle its last slice leaves, so words run back to back.
    always_comb begin
        serial_d = serial_q;
        rem_d    = rem_q;
        msb_d    = msb_q;
        hold_wr  = 1'b0;
        hold_rd  = 1'b0;
        if (FLUSH) begin
            serial_d = '0;
            rem_d    = '0;
            msb_d    = 1'b0;
        end else begin
            if (fire) begin
                serial_d = msb_q ? (serial_q << DATA_OUT_WIDTH) : (serial_q >> DATA_OUT_WIDTH);
                rem_d    = rem_q - COUNT_WIDTH'(1);
            end
            if (free && hold_valid) begin
                serial_d = hold_data;
                rem_d    = hold_cnt;
                msb_d    = hold_msb;
                hold_rd  = 1'b1;
                hold_wr  = in_accept;
            end else if (free && in_accept) begin
                serial_d = DATA_IN;
                rem_d    = in_cnt_norm;
                msb_d    = IN_MSB_FIRST;
            end else begin
                hold_wr  = in_accept;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            serial_q <= '0;
            rem_q    <= '0;
            msb_q    <= 1'b0;
        end else begin
            serial_q <= serial_d;
            rem_q    <= rem_d;
            msb_q    <= msb_d;
        end
    end

    always_comb begin
        IN_READY  = in_ready;
        OUT_VALID = (rem_q != '0);
        OUT_LAST  = (rem_q == COUNT_WIDTH'(1));
        DATA_OUT  = msb_q ? serial_q[DATA_IN_WIDTH-1 -: DATA_OUT_WIDTH]
                          : serial_q[DATA_OUT_WIDTH-1:0];
        BUSY      = (rem_q != '0) || hold_valid;
    end

endmodule

// File: tb/tb_piso_stream.sv
// tb/tb_piso_stream.sv - directed and randomized self-checking bench for piso_stream
module tb_piso_stream;

    localparam int IW = 64;
    localparam int OW = 16;
    localparam int NS = IW / OW;
    localparam int CW = 3;

    logic          CLK = 1'b0;
    logic          RESET, FLUSH, IN_VALID, IN_MSB_FIRST, OUT_READY;
    logic [IW-1:0] DATA_IN;
    logic [CW-1:0] IN_COUNT;
    logic          IN_READY, OUT_VALID, OUT_LAST, BUSY;
    logic [OW-1:0] DATA_OUT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
    } slice_t;

    slice_t sb[$];

    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data;
    logic          prev_last;

    piso_stream #(
        .DATA_IN_WIDTH  (IW),
        .DATA_OUT_WIDTH (OW)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .FLUSH        (FLUSH),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .DATA_IN      (DATA_IN),
        .IN_COUNT     (IN_COUNT),
        .IN_MSB_FIRST (IN_MSB_FIRST),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .DATA_OUT     (DATA_OUT),
        .OUT_LAST     (OUT_LAST),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: an accepted word expands into its list of slices in emission order.
    task automatic push_word(input logic [IW-1:0] w, input logic [CW-1:0] cnt, input logic msb);
        int n;
        int idx;
        slice_t s;
        n = (cnt == 0 || int'(cnt) > NS) ? NS : int'(cnt);
        for (int i = 0; i < n; i++) begin
            idx    = msb ? (NS - 1 - i) : i;
            s.data = w[idx*OW +: OW];
            s.last = (i == n - 1);
            sb.push_back(s);
        end
    endtask

    // Inputs change 1 time unit after posedge, so at negedge they equal what the next edge samples.
    always @(negedge CLK) begin
        slice_t e;
        if (RESET || FLUSH) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(OUT_VALID), 64'(1'b1));
                check("stall_data", 64'(DATA_OUT), 64'(prev_data));
                check("stall_last", 64'(OUT_LAST), 64'(prev_last));
            end
            if (OUT_VALID && OUT_READY) begin
                if (sb.size() == 0) begin
                    check("unexpected_slice", 64'(DATA_OUT), 64'hDEAD_0000_0000_BEEF);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", 64'(DATA_OUT), 64'(e.data));
                    check("sb_last", 64'(OUT_LAST), 64'(e.last));
                end
            end
            if (IN_VALID && IN_READY) begin
                push_word(DATA_IN, IN_COUNT, IN_MSB_FIRST);
            end
            prev_stall = OUT_VALID && !OUT_READY;
            prev_data  = DATA_OUT;
            prev_last  = OUT_LAST;
        end
    end

    task automatic send_word(input logic [IW-1:0] w, input logic [CW-1:0] cnt, input logic msb);
        bit done = 1'b0;
        DATA_IN      = w;
        IN_COUNT     = cnt;
        IN_MSB_FIRST = msb;
        IN_VALID     = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            done = IN_READY;
            tick();
        end
        if (!done) check("send_timeout", 64'(done), 64'(1'b1));
        IN_VALID = 1'b0;
    endtask

    task automatic drain(input string tag);
        OUT_READY = 1'b1;
        IN_VALID  = 1'b0;
        for (int i = 0; i < 40 && BUSY; i++) tick();
        check({tag, "_busy"}, 64'(BUSY), 64'(1'b0));
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        logic [IW-1:0] w;
        logic [IW-1:0] words [4];
        bit            acc;
        int            n;

        RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; IN_MSB_FIRST = 1'b0;
        OUT_READY = 1'b0; DATA_IN = '0; IN_COUNT = '0;
        tick(); tick();
        check("rst_in_ready_low", 64'(IN_READY), 64'(1'b0));
        RESET = 1'b0;
        #1;
        check("rst_out_valid", 64'(OUT_VALID), 64'(1'b0));
        check("rst_out_last", 64'(OUT_LAST), 64'(1'b0));
        check("rst_data_out", 64'(DATA_OUT), 64'(0));
        check("rst_busy", 64'(BUSY), 64'(1'b0));
        check("rst_in_ready_high", 64'(IN_READY), 64'(1'b1));

        // Full word, LSB first
        w = 64'h4444_3333_2222_1111;
        OUT_READY = 1'b1;
        send_word(w, 3'd0, 1'b0);
        for (int i = 0; i < NS; i++) begin
            check("lsb_valid", 64'(OUT_VALID), 64'(1'b1));
            check("lsb_data", 64'(DATA_OUT), 64'(w[i*OW +: OW]));
            check("lsb_last", 64'(OUT_LAST), 64'(i == NS - 1));
            tick();
        end
        check("lsb_busy_fall", 64'(BUSY), 64'(1'b0));

        // MSB first, partial count
        send_word(w, 3'd2, 1'b1);
        check("msb_s0", 64'(DATA_OUT), 64'h4444);
        check("msb_s0_last", 64'(OUT_LAST), 64'(1'b0));
        tick();
        check("msb_s1", 64'(DATA_OUT), 64'h3333);
        check("msb_s1_last", 64'(OUT_LAST), 64'(1'b1));
        tick();
        check("msb_idle", 64'(OUT_VALID), 64'(1'b0));

        // Back-to-back count-1 words at one slice per cycle
        for (int i = 0; i < 4; i++) words[i] = {$urandom, $urandom};
        IN_COUNT = 3'd1; IN_MSB_FIRST = 1'b0; IN_VALID = 1'b1;
        DATA_IN = words[0];
        check("b2b_in_ready", 64'(IN_READY), 64'(1'b1));
        tick();
        for (int i = 1; i < 4; i++) begin
            DATA_IN = words[i];
            check("b2b_data", 64'(DATA_OUT), 64'(words[i-1][OW-1:0]));
            check("b2b_last", 64'(OUT_LAST), 64'(1'b1));
            check("b2b_in_ready", 64'(IN_READY), 64'(1'b1));
            tick();
        end
        IN_VALID = 1'b0;
        check("b2b_data", 64'(DATA_OUT), 64'(words[3][OW-1:0]));
        check("b2b_last", 64'(OUT_LAST), 64'(1'b1));
        tick();
        check("b2b_idle", 64'(OUT_VALID), 64'(1'b0));

        // Backpressure with a word parked in hold and a third word stalled
        w = {$urandom, $urandom};
        send_word(w, 3'd0, 1'b0);
        tick();
        OUT_READY = 1'b0;
        DATA_IN = {$urandom, $urandom}; IN_COUNT = 3'd0; IN_MSB_FIRST = 1'b1; IN_VALID = 1'b1;
        tick();
        check("bp_in_ready", 64'(IN_READY), 64'(1'b0));
        check("bp_data", 64'(DATA_OUT), 64'(w[OW +: OW]));
        DATA_IN = {$urandom, $urandom}; IN_COUNT = 3'd3; IN_MSB_FIRST = 1'b0;
        tick();
        check("bp_in_ready", 64'(IN_READY), 64'(1'b0));
        check("bp_data", 64'(DATA_OUT), 64'(w[OW +: OW]));
        check("bp_busy", 64'(BUSY), 64'(1'b1));
        tick();
        check("bp_data", 64'(DATA_OUT), 64'(w[OW +: OW]));
        OUT_READY = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = IN_READY;
            tick();
        end
        check("bp_third_accepted", 64'(acc), 64'(1'b1));
        IN_VALID = 1'b0;
        drain("bp");

        // Flush with a live hold entry
        w = {$urandom, $urandom};
        send_word(w, 3'd0, 1'b0);
        tick();
        DATA_IN = {$urandom, $urandom}; IN_COUNT = 3'd0; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        check("fl_hold_full", 64'(IN_READY), 64'(1'b0));
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        check("fl_out_valid", 64'(OUT_VALID), 64'(1'b0));
        check("fl_busy", 64'(BUSY), 64'(1'b0));
        check("fl_in_ready", 64'(IN_READY), 64'(1'b1));
        w = {$urandom, $urandom};
        send_word(w, 3'd0, 1'b0);
        check("fl_restart_data", 64'(DATA_OUT), 64'(w[OW-1:0]));
        check("fl_restart_last", 64'(OUT_LAST), 64'(1'b0));
        drain("fl");

        // Count saturation
        send_word({$urandom, $urandom}, 3'd7, 1'b0);
        n = 0;
        for (int i = 0; i < 10 && OUT_VALID; i++) begin
            n++;
            tick();
        end
        check("sat_slices", 64'(n), 64'(NS));

        // Reset mid-word
        send_word({$urandom, $urandom}, 3'd0, 1'b1);
        tick();
        RESET = 1'b1;
        tick();
        check("rmid_valid", 64'(OUT_VALID), 64'(1'b0));
        check("rmid_last", 64'(OUT_LAST), 64'(1'b0));
        check("rmid_data", 64'(DATA_OUT), 64'(0));
        check("rmid_busy", 64'(BUSY), 64'(1'b0));
        check("rmid_in_ready", 64'(IN_READY), 64'(1'b0));
        RESET = 1'b0;
        #1;
        check("rmid_in_ready_after", 64'(IN_READY), 64'(1'b1));

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 1500; c++) begin
            if (!IN_VALID && $urandom_range(0, 2) != 0) begin
                DATA_IN      = {$urandom, $urandom};
                IN_COUNT     = 3'($urandom_range(0, 7));
                IN_MSB_FIRST = 1'($urandom_range(0, 1));
                IN_VALID     = 1'b1;
            end
            OUT_READY = ($urandom_range(0, 3) != 0);
            acc = IN_VALID && IN_READY;
            tick();
            if (acc) IN_VALID = 1'b0;
        end
        drain("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised, flow-controlled successor to the basic parallel-in/serial-out shifter.
- Accepts a DATA_IN_WIDTH word on a valid/ready input.
- Emits up to NUM_SHIFTS = DATA_IN_WIDTH/DATA_OUT_WIDTH slices on a valid/ready output, in LSB-first or MSB-first order, with a per-word slice count and a last-slice flag.
- A one-entry holding buffer plus a bypass path sustains one output slice per cycle across word boundaries. Sits between wide on-chip buffers and narrow PE/stream datapaths.

Parameters:
- DATA_IN_WIDTH, 64, width of the parallel input word.
- DATA_OUT_WIDTH, 16, width of each serial slice. DATA_IN_WIDTH must be an integer multiple, with NUM_SHIFTS >= 2.
- COUNT_WIDTH, clog2(NUM_SHIFTS+1) (derived), width of the slice-count field.

Ports:
- CLK  in  1  clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- FLUSH  in  1  synchronous drop of all buffered data.
- IN_VALID  in  1  input word valid.
- IN_READY  out  1  input can accept; equals !hold_valid && !RESET.
- DATA_IN  in  DATA_IN_WIDTH  parallel word.
- IN_COUNT  in  COUNT_WIDTH  slices to emit for this word. 0 means NUM_SHIFTS; values > NUM_SHIFTS saturate to NUM_SHIFTS.
- IN_MSB_FIRST  in  1  per-word order: 1 means the top slice is emitted first.
- OUT_VALID  out  1  slice valid.
- OUT_READY  in  1  downstream accepts slice.
- DATA_OUT  out  DATA_OUT_WIDTH  current slice.
- OUT_LAST  out  1  current slice is the final slice of its word.
- BUSY  out  1  OUT_VALID || hold_valid.

Behaviour:
- State
  - Shift register `serial`, remaining count `rem`, latched order bit `msb`.
  - Holding register `hold` with `hold_cnt`, `hold_msb` and `hold_valid`.
- Reset: while RESET is high, all registers clear and IN_READY = 0. After reset, OUT_VALID = 0, OUT_LAST = 0, DATA_OUT = 0, BUSY = 0, IN_READY = 1.
- Outputs
  - OUT_VALID = (rem != 0).
  - OUT_LAST = (rem == 1).
  - DATA_OUT = serial[DATA_OUT_WIDTH-1:0] when msb = 0, else serial[DATA_IN_WIDTH-1 -: DATA_OUT_WIDTH]. Combinational from registers, no added latency.
- Output fire (OUT_VALID && OUT_READY)
  - msb = 0: serial shifts right by DATA_OUT_WIDTH.
  - msb = 1: serial shifts left by DATA_OUT_WIDTH.
  - In both cases zeros fill, and rem decrements.
- Stall: while OUT_VALID && !OUT_READY, DATA_OUT, OUT_LAST and rem hold stable.
- Define `free` = (rem == 0) || (fire && rem == 1).
- Load priority each cycle, evaluated after FLUSH:
  1. If free && hold_valid: move hold into serial/rem/msb and clear hold_valid. In the same cycle, an accepted input is written into hold.
  2. Else if free && input is accepted: the input bypasses hold and loads serial directly.
  3. Else if input is accepted: write the input into hold.
- Throughput and latency
  - Back-to-back words with IN_COUNT = 1 sustain one slice per cycle.
  - Input-to-first-slice latency is 1 cycle when the datapath is idle.
- MSB-first with a partial count emits the top IN_COUNT slices of the word, highest slice first.
- FLUSH has priority over all loads and fires. It clears rem and hold_valid; the input is not accepted that cycle (IN_READY remains as defined, but the data is discarded). RESET has priority over FLUSH.
- Reset or flush mid-word: the remaining slices are discarded and no partial OUT_LAST is issued.
- The order bit is captured per word, so mixed-order streams are legal.

Decomposition:
- Shared package (dnnweaver primitives) holds:
  - the NUM_SHIFTS/COUNT_WIDTH derivation function;
  - the count-normalisation function (0 or >NUM_SHIFTS maps to NUM_SHIFTS).
- No sub-module is needed. The hold/bypass entry may optionally be factored as `piso_hold_buf`; the shift and count logic stays inline.

Test Plan:
- Reset, then a single word 0x4444_3333_2222_1111 with count 0, LSB-first, OUT_READY = 1 -> DATA_OUT sequence 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles; OUT_LAST only on 0x4444; BUSY falls the cycle after.
- Same word, MSB-first, count 2 -> 0x4444 then 0x3333 with OUT_LAST; then idle.
- Four words, each count 1, IN_VALID held high, OUT_READY = 1 -> four slices in four consecutive cycles; OUT_LAST high on every slice; IN_READY never low.
- Backpressure: OUT_READY low for 3 cycles mid-word while a second word arrives -> second word sits in hold; IN_READY = 0; third word is stalled; DATA_OUT is stable during the stall; word order is preserved.
- FLUSH asserted after the second slice of a full word with a valid hold entry -> OUT_VALID = 0 and BUSY = 0 the next cycle; the next accepted word starts cleanly at its first slice.
- Count saturation: count 7 with NUM_SHIFTS = 4 -> exactly 4 slices. RESET mid-word -> all outputs return to their reset values on the following cycle.
